adc_hex_reporter: RTL and testbench



---
 rtl/adc_hex_reporter_pkg.sv | 24 ++
 rtl/adc_hex_reporter_rr_arbiter.sv | 28 ++
 rtl/adc_hex_reporter.sv | 140 ++++++++++++++
 tb/tb_adc_hex_reporter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_hex_reporter_pkg.sv
// Shared definitions for the multi-channel ADC hex reporter: ASCII constants,
// frame state encoding and the nibble-to-ASCII helper.
package adc_hex_reporter_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_E     = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_COLON,
    S_HEX,
    S_ERR,
    S_CR,
    S_LF
  } state_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/adc_hex_reporter_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index strictly after ptr,
// wrapping around, so the previously served channel has lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] grant,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/adc_hex_reporter.sv
// Multi-channel ADC sample buffer that reports pending channels round-robin as
// ASCII frames "<tag>:<hex>\r\n" to a uart_tx, plus "E\r\n" error frames.
module adc_hex_reporter
  import adc_hex_reporter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int TAG_EN = 1
) (
  input  logic                     i_Clk,
  input  logic                     w_rst,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH-1:0]        i_valid,
  input  logic                     i_error,
  input  logic                     i_tx_busy,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  output logic [NUM_CH-1:0]        o_overrun,
  output logic                     o_busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ND = DATA_W / 4;
  localparam logic [2:0] DLAST = 3'(ND - 1);

  logic [DATA_W-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     tag;
  logic              any;
  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        dcnt;
  logic              error_sent;
  logic [3:0]        nib;
  logic [7:0]        byte_out;
  logic              can_issue;
  logic              start_err;
  logic              pick;

  rr_arbiter #(.N(NUM_CH), .CW(CW)) u_arb (
    .req  (pend),
    .ptr  (ptr),
    .grant(grant),
    .any  (any)
  );

  // Single hex_to_ascii shared by tag and digits through the nibble mux.
  always_comb begin
    can_issue = !i_tx_busy && !o_tx_start;
    start_err = (state == S_IDLE) && i_error && !error_sent;
    pick      = (state == S_IDLE) && !start_err && any;
    nib       = (state == S_TAG) ? 4'(tag) : shift_reg[DATA_W-1 -: 4];
    case (state)
      S_TAG, S_HEX: byte_out = hex_to_ascii(nib);
      S_COLON:      byte_out = ASCII_COLON;
      S_ERR:        byte_out = ASCII_E;
      S_CR:         byte_out = ASCII_CR;
      S_LF:         byte_out = ASCII_LF;
      default:      byte_out = '0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (w_rst) begin
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overrun  <= '0;
      o_busy     <= 1'b0;
      pend       <= '0;
      ptr        <= CW'(NUM_CH - 1);
      tag        <= '0;
      shift_reg  <= '0;
      dcnt       <= '0;
      error_sent <= 1'b0;
      state      <= S_IDLE;
      for (int unsigned k = 0; k < NUM_CH; k++) hold[k] <= '0;
    end else begin
      o_tx_start <= 1'b0;

      // A capture on the channel being selected keeps it pending (set wins).
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (i_valid[k]) begin
          hold[k] <= i_data[k*DATA_W +: DATA_W];
          pend[k] <= 1'b1;
          if (pend[k] && !(pick && grant == CW'(k))) o_overrun[k] <= 1'b1;
        end else if (pick && grant == CW'(k)) begin
          pend[k] <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (start_err) begin
            o_busy <= 1'b1;
            state  <= S_ERR;
          end else if (any) begin
            shift_reg <= hold[grant];
            tag       <= grant;
            ptr       <= grant;
            dcnt      <= DLAST;
            o_busy    <= 1'b1;
            state     <= (TAG_EN != 0) ? S_TAG : S_HEX;
          end
        end
        default: begin
          if (can_issue) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= byte_out;
            case (state)
              S_TAG:   state <= S_COLON;
              S_COLON: begin
                dcnt  <= DLAST;
                state <= S_HEX;
              end
              S_HEX: begin
                shift_reg <= shift_reg << 4;
                if (dcnt == 3'd0) state <= S_CR;
                else dcnt <= dcnt - 3'd1;
              end
              S_ERR: begin
                error_sent <= 1'b1;
                state      <= S_CR;
              end
              S_CR: state <= S_LF;
              default: begin
                o_busy <= 1'b0;
                state  <= S_IDLE;
              end
            endcase
          end
        end
      endcase

      if (!i_error) error_sent <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_hex_reporter.sv
// Scoreboard bench: expected frames are queued when samples are issued and
// monitors compare every o_tx_start byte against the queue head.
module tb_adc_hex_reporter;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int NCH2 = 2;
  localparam int DW2  = 12;

  logic i_Clk = 1'b0;
  logic w_rst;
  always #5 i_Clk = ~i_Clk;

  logic [NCH*DW-1:0] data1;
  logic [NCH-1:0]    valid1;
  logic              err1;
  logic              busy1;
  logic [7:0]        tx_data1;
  logic              tx_start1;
  logic [NCH-1:0]    ovr1;
  logic              obusy1;

  logic [NCH2*DW2-1:0] data2;
  logic [NCH2-1:0]     valid2;
  logic                err2;
  logic                busy2;
  logic [7:0]          tx_data2;
  logic                tx_start2;
  logic [NCH2-1:0]     ovr2;
  logic                obusy2;

  adc_hex_reporter #(.NUM_CH(NCH), .DATA_W(DW), .TAG_EN(1)) dut1 (
    .i_Clk(i_Clk), .w_rst(w_rst), .i_data(data1), .i_valid(valid1),
    .i_error(err1), .i_tx_busy(busy1), .o_tx_data(tx_data1),
    .o_tx_start(tx_start1), .o_overrun(ovr1), .o_busy(obusy1)
  );

  adc_hex_reporter #(.NUM_CH(NCH2), .DATA_W(DW2), .TAG_EN(0)) dut2 (
    .i_Clk(i_Clk), .w_rst(w_rst), .i_data(data2), .i_valid(valid2),
    .i_error(err2), .i_tx_busy(busy2), .o_tx_data(tx_data2),
    .o_tx_start(tx_start2), .o_overrun(ovr2), .o_busy(obusy2)
  );

  int checks = 0;
  int failures = 0;
  byte unsigned q1[$];
  byte unsigned q2[$];
  int starts1 = 0;
  int starts2 = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  int busy_len = 10;
  int bcnt = 0;
  int mptr;
  logic [NCH-1:0] exp_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic byte unsigned hexc(input int v);
    return (v < 10) ? byte'(48 + v) : byte'(55 + v);
  endfunction

  task automatic push_frame1(input int ch, input logic [DW-1:0] v);
    q1.push_back(hexc(ch));
    q1.push_back(8'h3A);
    for (int i = DW/4 - 1; i >= 0; i--) q1.push_back(hexc(int'(v[i*4 +: 4])));
    q1.push_back(8'h0D);
    q1.push_back(8'h0A);
  endtask

  task automatic push_frame2(input logic [DW2-1:0] v);
    for (int i = DW2/4 - 1; i >= 0; i--) q2.push_back(hexc(int'(v[i*4 +: 4])));
    q2.push_back(8'h0D);
    q2.push_back(8'h0A);
  endtask

  // uart_tx model: busy rises the cycle after a start and lasts busy_len cycles.
  always @(posedge i_Clk) begin
    if (w_rst) begin
      busy1 <= 1'b0;
      bcnt  <= 0;
    end else if (tx_start1) begin
      busy1 <= 1'b1;
      bcnt  <= (busy_len > 0) ? busy_len : int'($urandom_range(1, 12));
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt  <= 0;
      busy1 <= 1'b0;
    end
  end

  always @(negedge i_Clk) begin
    if (tx_start1) begin
      starts1++;
      check("dut1_start_width", {63'd0, prev1}, 64'd0);
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_byte actual=%0h expected=no byte", tx_data1);
      end else begin
        check("dut1_byte", {56'd0, tx_data1}, {56'd0, q1.pop_front()});
      end
    end
    if (tx_start2) begin
      starts2++;
      check("dut2_start_width", {63'd0, prev2}, 64'd0);
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_unexpected_byte actual=%0h expected=no byte", tx_data2);
      end else begin
        check("dut2_byte", {56'd0, tx_data2}, {56'd0, q2.pop_front()});
      end
    end
    prev1 = tx_start1;
    prev2 = tx_start2;
  end

  task automatic wait_idle1(input string name);
    int n = 0;
    repeat (3) @(negedge i_Clk);
    while (!(q1.size() == 0 && !obusy1) && n < 4000) begin
      @(negedge i_Clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL %s timeout actual queue=%0d busy=%0b expected drained and idle", name, q1.size(), obusy1);
    end
  endtask

  task automatic wait_idle2(input string name);
    int n = 0;
    repeat (3) @(negedge i_Clk);
    while (!(q2.size() == 0 && !obusy2) && n < 2000) begin
      @(negedge i_Clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s timeout actual queue=%0d busy=%0b expected drained and idle", name, q2.size(), obusy2);
    end
  endtask

  task automatic wait_starts1(input int target, input string name);
    int n = 0;
    while (starts1 < target && n < 2000) begin
      @(negedge i_Clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s timeout actual starts=%0d expected %0d", name, starts1, target);
    end
  endtask

  task automatic strobe1(input int ch, input logic [DW-1:0] v);
    @(negedge i_Clk);
    data1[ch*DW +: DW] = v;
    valid1 = NCH'(1) << ch;
    @(negedge i_Clk);
    valid1 = '0;
  endtask

  task automatic strobe2(input int ch, input logic [DW2-1:0] v);
    @(negedge i_Clk);
    data2[ch*DW2 +: DW2] = v;
    valid2 = NCH2'(1) << ch;
    @(negedge i_Clk);
    valid2 = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, {56'd0, tx_data1}, 64'd0);
    check({tag, "_tx_start"}, {63'd0, tx_start1}, 64'd0);
    check({tag, "_overrun"}, {60'd0, ovr1}, 64'd0);
    check({tag, "_busy"}, {63'd0, obusy1}, 64'd0);
  endtask

  initial begin
    int base;
    logic [DW-1:0] vals [NCH];
    logic [DW2-1:0] v2;
    int mask;
    int last;

    w_rst = 1'b1; data1 = '0; valid1 = '0; err1 = 1'b0;
    data2 = '0; valid2 = '0; err2 = 1'b0; busy2 = 1'b0;
    exp_ovr = '0;
    mptr = NCH - 1;
    repeat (3) @(negedge i_Clk);
    check_reset_outputs("reset");
    check("reset_dut2_busy", {63'd0, obusy2}, 64'd0);
    w_rst = 1'b0;

    // Single sample on ch2.
    base = starts1;
    push_frame1(2, 16'h1A2F);
    strobe1(2, 16'h1A2F);
    wait_idle1("single_idle");
    check("single_start_count", 64'(starts1 - base), 64'd8);
    check("single_overrun", {60'd0, ovr1}, 64'd0);
    mptr = 2;

    // Narrow, untagged instance with uart never busy.
    base = starts2;
    push_frame2(12'hABC);
    strobe2(0, 12'hABC);
    wait_idle2("width_idle");
    check("width_start_count", 64'(starts2 - base), 64'd5);
    for (int i = 0; i < 6; i++) begin
      v2 = DW2'($urandom);
      push_frame2(v2);
      strobe2(int'($urandom_range(0, NCH2 - 1)), v2);
      wait_idle2("width_rand_idle");
    end

    // Reset after the third byte of a frame.
    base = starts1;
    vals[0] = DW'($urandom);
    push_frame1(0, vals[0]);
    strobe1(0, vals[0]);
    wait_starts1(base + 3, "reset_third_byte");
    w_rst = 1'b1;
    q1.delete();
    repeat (2) @(negedge i_Clk);
    check_reset_outputs("midreset");
    w_rst = 1'b0;
    base = starts1;
    repeat (30) @(negedge i_Clk);
    check("midreset_no_start", 64'(starts1 - base), 64'd0);
    mptr = NCH - 1;
    vals[3] = DW'($urandom);
    push_frame1(3, vals[3]);
    strobe1(3, vals[3]);
    wait_idle1("after_reset_idle");
    check("after_reset_count", 64'(starts1 - base), 64'd8);
    mptr = 3;

    // Round robin: all four in one cycle, served 0,1,2,3.
    @(negedge i_Clk);
    for (int c = 0; c < NCH; c++) begin
      data1[c*DW +: DW] = DW'(c * 16'h1111);
      push_frame1(c, DW'(c * 16'h1111));
    end
    valid1 = '1;
    @(negedge i_Clk);
    valid1 = '0;
    wait_idle1("rr_idle");
    check("rr_busy_after", {63'd0, obusy1}, 64'd0);
    mptr = NCH - 1;

    // Overrun on ch1 while ch0 frame is in progress.
    vals[0] = DW'($urandom);
    push_frame1(0, vals[0]);
    strobe1(0, vals[0]);
    repeat (5) @(negedge i_Clk);
    strobe1(1, 16'h0001);
    repeat (5) @(negedge i_Clk);
    strobe1(1, 16'h0002);
    push_frame1(1, 16'h0002);
    exp_ovr = 4'b0010;
    check("overrun_set", {60'd0, ovr1}, {60'd0, exp_ovr});
    wait_idle1("overrun_idle");
    check("overrun_sticky", {60'd0, ovr1}, {60'd0, exp_ovr});
    mptr = 1;

    // Error raised mid-HEX of a ch3 frame, then re-armed.
    base = starts1;
    vals[3] = DW'($urandom);
    push_frame1(3, vals[3]);
    q1.push_back(8'h45); q1.push_back(8'h0D); q1.push_back(8'h0A);
    strobe1(3, vals[3]);
    wait_starts1(base + 4, "err_mid_hex");
    err1 = 1'b1;
    repeat (300) @(negedge i_Clk);
    wait_idle1("err_idle");
    check("err_once_count", 64'(starts1 - base), 64'd11);
    err1 = 1'b0;
    repeat (3) @(negedge i_Clk);
    base = starts1;
    q1.push_back(8'h45); q1.push_back(8'h0D); q1.push_back(8'h0A);
    err1 = 1'b1;
    repeat (200) @(negedge i_Clk);
    wait_idle1("err2_idle");
    check("err_rearm_count", 64'(starts1 - base), 64'd3);
    err1 = 1'b0;
    mptr = 3;

    // Random subsets strobed together, random uart busy length.
    busy_len = 0;
    for (int it = 0; it < 25; it++) begin
      mask = int'($urandom_range(1, (1 << NCH) - 1));
      @(negedge i_Clk);
      for (int c = 0; c < NCH; c++) begin
        vals[c] = DW'($urandom);
        data1[c*DW +: DW] = vals[c];
      end
      valid1 = NCH'(mask);
      last = mptr;
      for (int j = 1; j <= NCH; j++) begin
        int ch;
        ch = (mptr + j) % NCH;
        if (mask[ch]) begin
          push_frame1(ch, vals[ch]);
          last = ch;
        end
      end
      mptr = last;
      @(negedge i_Clk);
      valid1 = '0;
      wait_idle1("rand_idle");
    end
    check("rand_overrun_sticky", {60'd0, ovr1}, {60'd0, exp_ovr});
    check("final_q1_empty", 64'(q1.size()), 64'd0);
    check("final_q2_empty", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
